// File: rtl/event_marker_decode_pkg.sv
// Shared constants and lock-state encoding for the EVR event marker decoder.
package event_marker_decode_pkg;

  localparam logic [7:0] HEARTBEAT_CODE_DEFAULT = 8'h7A;
  localparam logic [7:0] PPS_CODE_DEFAULT       = 8'h7D;
  localparam int         INTERVAL_WIDTH_DEFAULT = 28;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ARMED    = 2'd1,
    LOCKED   = 2'd2
  } lockState_t;

endpackage

// File: rtl/event_marker_decode_marker_stretch.sv
// Stretches a single-cycle marker event to MARKER_WIDTH cycles.
// A new event while the marker is still high is ignored, so the pulse is never extended.
module marker_stretch
  import event_marker_decode_pkg::*;
#(
  parameter int MARKER_WIDTH = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic trigger,
  output logic marker
);

  localparam logic [3:0] WIDTH_LOAD = 4'(MARKER_WIDTH);

  logic [3:0] remaining;

  // Down-counter: load on an event only while idle, otherwise count down to zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      remaining <= '0;
    end else if (trigger && (remaining == '0)) begin
      remaining <= WIDTH_LOAD;
    end else if (remaining != '0) begin
      remaining <= remaining - 4'd1;
    end
  end

  assign marker = (remaining != '0);

endmodule

// File: rtl/event_marker_decode.sv
// EVR event-code decoder: heartbeat/PPS markers, heartbeat period measurement,
// heartbeat lock tracking and wrap-around event counters.
//
// Lock FSM states:
//   state    | meaning
//   UNLOCKED | no reference heartbeat, or timed out, or lock tracking disabled
//   ARMED    | reference heartbeat seen, counting consecutive matching intervals
//   LOCKED   | LOCK_COUNT consecutive intervals matched expectedInterval
module event_marker_decode
  import event_marker_decode_pkg::*;
#(
  parameter logic [7:0] HEARTBEAT_CODE = HEARTBEAT_CODE_DEFAULT,
  parameter logic [7:0] PPS_CODE       = PPS_CODE_DEFAULT,
  parameter int         MARKER_WIDTH   = 4,
  parameter int         INTERVAL_WIDTH = INTERVAL_WIDTH_DEFAULT,
  parameter int         LOCK_COUNT     = 3,
  parameter string      DEBUG          = "false"
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [7:0]                evCode,
  input  logic                      evCodeValid,
  input  logic [INTERVAL_WIDTH-1:0] expectedInterval,
  output logic                      heartbeatMarker,
  output logic                      pulsePerSecondMarker,
  output logic [INTERVAL_WIDTH-1:0] heartbeatInterval,
  output logic                      heartbeatIntervalStrobe,
  output logic                      heartbeatLocked,
  output logic [15:0]               heartbeatCount,
  output logic [15:0]               ppsCount
);

  localparam logic [INTERVAL_WIDTH-1:0] INTERVAL_MAX = '1;
  localparam logic [INTERVAL_WIDTH-1:0] INTERVAL_ONE = INTERVAL_WIDTH'(1);
  localparam logic [2:0]                LOCK_TARGET  = 3'(LOCK_COUNT);

  logic hbEvent;
  logic ppsEvent;

  logic [INTERVAL_WIDTH-1:0] intervalCnt;
  logic                      hbSeen;

  lockState_t state, nextState;
  logic [2:0] matchCount, nextMatchCount;

  logic intervalMatch;
  logic intervalTimeout;
  logic lockDisabled;

  assign hbEvent  = evCodeValid && (evCode == HEARTBEAT_CODE);
  assign ppsEvent = evCodeValid && (evCode == PPS_CODE);

  marker_stretch #(.MARKER_WIDTH(MARKER_WIDTH)) uHeartbeatStretch (
    .clk     (clk),
    .resetN  (resetN),
    .trigger (hbEvent),
    .marker  (heartbeatMarker)
  );

  marker_stretch #(.MARKER_WIDTH(MARKER_WIDTH)) uPpsStretch (
    .clk     (clk),
    .resetN  (resetN),
    .trigger (ppsEvent),
    .marker  (pulsePerSecondMarker)
  );

  // Wrap-around event counters for status readback.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      heartbeatCount <= '0;
      ppsCount       <= '0;
    end else begin
      if (hbEvent)  heartbeatCount <= heartbeatCount + 16'd1;
      if (ppsEvent) ppsCount       <= ppsCount + 16'd1;
    end
  end

  // Cycles since the last heartbeat; reloads to 1 so heartbeats at t0,t1 read t1-t0.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      intervalCnt <= '0;
    end else if (hbEvent) begin
      intervalCnt <= INTERVAL_ONE;
    end else if (intervalCnt != INTERVAL_MAX) begin
      intervalCnt <= intervalCnt + INTERVAL_ONE;
    end
  end

  // Latch the measured period; the first heartbeat only establishes the reference.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hbSeen                  <= 1'b0;
      heartbeatInterval       <= '0;
      heartbeatIntervalStrobe <= 1'b0;
    end else begin
      heartbeatIntervalStrobe <= hbEvent && hbSeen;
      if (hbEvent) begin
        hbSeen <= 1'b1;
        if (hbSeen) heartbeatInterval <= intervalCnt;
      end
    end
  end

  assign intervalMatch   = (intervalCnt == expectedInterval);
  assign intervalTimeout = (intervalCnt > expectedInterval);
  assign lockDisabled    = (expectedInterval == '0);

  // Lock FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= UNLOCKED;
      matchCount <= '0;
    end else begin
      state      <= nextState;
      matchCount <= nextMatchCount;
    end
  end

  // Lock FSM next state; a heartbeat takes priority over a same-cycle timeout.
  always_comb begin
    nextState      = state;
    nextMatchCount = matchCount;
    if (lockDisabled) begin
      nextState      = UNLOCKED;
      nextMatchCount = '0;
    end else if (hbEvent) begin
      case (state)
        UNLOCKED: begin
          nextState      = ARMED;
          nextMatchCount = '0;
        end
        ARMED: begin
          if (intervalMatch) begin
            if ((matchCount + 3'd1) == LOCK_TARGET) begin
              nextState      = LOCKED;
              nextMatchCount = '0;
            end else begin
              nextMatchCount = matchCount + 3'd1;
            end
          end else begin
            nextMatchCount = '0;
          end
        end
        LOCKED: begin
          if (!intervalMatch) begin
            nextState      = ARMED;
            nextMatchCount = '0;
          end
        end
        default: begin
          nextState      = UNLOCKED;
          nextMatchCount = '0;
        end
      endcase
    end else if ((state != UNLOCKED) && intervalTimeout) begin
      nextState      = UNLOCKED;
      nextMatchCount = '0;
    end
  end

  assign heartbeatLocked = (state == LOCKED);

  // Optional debug visibility of the lock FSM for on-chip logic analysers.
  if (DEBUG == "true") begin : gDebug
    (* mark_debug = "true" *) logic [1:0] debugState;
    (* mark_debug = "true" *) logic [2:0] debugMatchCount;
    assign debugState      = state;
    assign debugMatchCount = matchCount;
  end

endmodule

// File: tb/tb_event_marker_decode.sv
// Self-checking bench for event_marker_decode: event-timeline reference model,
// per-cycle compare process, directed scenarios plus randomized traffic.
module tb_event_marker_decode;

  localparam int         IW   = 12;
  localparam int         MW   = 4;
  localparam int         LC   = 3;
  localparam int         MAXV = (1 << IW) - 1;
  localparam logic [7:0] HB   = 8'h7A;
  localparam logic [7:0] PPS  = 8'h7D;

  logic          clk = 1'b0;
  logic          resetN = 1'b1;
  logic [7:0]    evCode = 8'h00;
  logic          evCodeValid = 1'b0;
  logic [IW-1:0] expectedInterval = '0;
  logic          heartbeatMarker;
  logic          pulsePerSecondMarker;
  logic [IW-1:0] heartbeatInterval;
  logic          heartbeatIntervalStrobe;
  logic          heartbeatLocked;
  logic [15:0]   heartbeatCount;
  logic [15:0]   ppsCount;

  event_marker_decode #(
    .MARKER_WIDTH   (MW),
    .INTERVAL_WIDTH (IW),
    .LOCK_COUNT     (LC)
  ) dut (
    .clk                     (clk),
    .resetN                  (resetN),
    .evCode                  (evCode),
    .evCodeValid             (evCodeValid),
    .expectedInterval        (expectedInterval),
    .heartbeatMarker         (heartbeatMarker),
    .pulsePerSecondMarker    (pulsePerSecondMarker),
    .heartbeatInterval       (heartbeatInterval),
    .heartbeatIntervalStrobe (heartbeatIntervalStrobe),
    .heartbeatLocked         (heartbeatLocked),
    .heartbeatCount          (heartbeatCount),
    .ppsCount                (ppsCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  // Reference model: absolute cycle numbers of events and marker end cycles.
  int cyc = 0;
  int mHbCnt, mPpsCnt;
  int hbEnd, ppsEnd;
  int lastHb;
  bit seen;
  bit armed, locked;
  int streak;
  int mInterval;
  bit mStrobe, mHbMark, mPpsMark;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mHbCnt = 0; mPpsCnt = 0;
    hbEnd = -1; ppsEnd = -1;
    lastHb = 0; seen = 0;
    armed = 0; locked = 0; streak = 0;
    mInterval = 0; mStrobe = 0; mHbMark = 0; mPpsMark = 0;
  endtask

  // Advance the model by one sampled cycle; expectations describe the following cycle.
  task automatic modelCycle(input bit v, input logic [7:0] code);
    bit hb, pp;
    int e, since;
    hb = v && (code == HB);
    pp = v && (code == PPS);
    e  = int'(expectedInterval);
    since = 0;
    if (seen) since = ((cyc - lastHb) > MAXV) ? MAXV : (cyc - lastHb);
    mStrobe = 0;
    if (hb) begin
      mHbCnt = (mHbCnt + 1) % 65536;
      if (cyc > hbEnd) hbEnd = cyc + MW;
      if (seen) begin
        mInterval = since;
        mStrobe = 1;
      end
    end
    if (pp) begin
      mPpsCnt = (mPpsCnt + 1) % 65536;
      if (cyc > ppsEnd) ppsEnd = cyc + MW;
    end
    if (e == 0) begin
      armed = 0; locked = 0; streak = 0;
    end else if (hb) begin
      if (!armed && !locked) begin
        armed = 1; streak = 0;
      end else if (since == e) begin
        if (armed) begin
          streak++;
          if (streak == LC) begin
            armed = 0; locked = 1; streak = 0;
          end
        end
      end else begin
        armed = 1; locked = 0; streak = 0;
      end
    end else if ((armed || locked) && since > e) begin
      armed = 0; locked = 0; streak = 0;
    end
    if (hb) begin
      seen = 1;
      lastHb = cyc;
    end
    mHbMark  = (cyc + 1 <= hbEnd);
    mPpsMark = (cyc + 1 <= ppsEnd);
    cyc++;
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      chk("heartbeatMarker", heartbeatMarker, mHbMark);
      chk("pulsePerSecondMarker", pulsePerSecondMarker, mPpsMark);
      chk("heartbeatIntervalStrobe", heartbeatIntervalStrobe, mStrobe);
      chk("heartbeatInterval", heartbeatInterval, mInterval);
      chk("heartbeatLocked", heartbeatLocked, locked);
      chk("heartbeatCount", heartbeatCount, mHbCnt);
      chk("ppsCount", ppsCount, mPpsCnt);
    end
  end

  task automatic step(input bit v, input logic [7:0] code);
    evCodeValid = v;
    evCode = code;
    @(posedge clk);
    #1;
    modelCycle(v, code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic hbAfter(input int gap);
    idle(gap - 1);
    step(1'b1, HB);
  endtask

  task automatic randCycle();
    logic [7:0] code;
    if ($urandom_range(0, 9) < 3) begin
      code = ($urandom_range(0, 1) == 0) ? PPS : 8'($urandom_range(0, 255));
      if (code == HB) code = 8'h00;
      step(1'b1, code);
    end else begin
      step(1'b0, 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic doReset();
    evCodeValid = 1'b0;
    resetN = 1'b0;
    modelReset();
    #1;
    chk("resetHbMarker", heartbeatMarker, 0);
    chk("resetPpsMarker", pulsePerSecondMarker, 0);
    chk("resetInterval", heartbeatInterval, 0);
    chk("resetStrobe", heartbeatIntervalStrobe, 0);
    chk("resetLocked", heartbeatLocked, 0);
    chk("resetHbCount", heartbeatCount, 0);
    chk("resetPpsCount", ppsCount, 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    int base, gap, e;
    modelReset();
    expectedInterval = 12'd1000;
    @(posedge clk);
    #1;
    doReset();
    checkEn = 1'b1;

    // Lock acquisition at 1000-cycle spacing.
    step(1'b1, HB);
    chk("firstHbNoStrobe", heartbeatIntervalStrobe, 0);
    for (int i = 0; i < 2; i++) begin
      hbAfter(1000);
      chk("acqInterval", heartbeatInterval, 1000);
      chk("acqStrobe", heartbeatIntervalStrobe, 1);
      chk("acqNotYetLocked", heartbeatLocked, 0);
    end
    hbAfter(1000);
    chk("acqLocked", heartbeatLocked, 1);

    // Timeout, then a late heartbeat.
    idle(1000);
    chk("preTimeoutLocked", heartbeatLocked, 1);
    idle(1);
    chk("timeoutUnlocked", heartbeatLocked, 0);
    idle(498);
    step(1'b1, HB);
    chk("lateInterval", heartbeatInterval, 1500);
    chk("lateUnlocked", heartbeatLocked, 0);
    for (int i = 0; i < 3; i++) hbAfter(1000);
    chk("relockAfterTimeout", heartbeatLocked, 1);

    // Single short interval drops lock; three good ones regain it.
    hbAfter(999);
    chk("mismatchInterval", heartbeatInterval, 999);
    chk("mismatchUnlocked", heartbeatLocked, 0);
    hbAfter(1000);
    hbAfter(1000);
    chk("mismatchStillArmed", heartbeatLocked, 0);
    hbAfter(1000);
    chk("mismatchRelock", heartbeatLocked, 1);

    // PPS retrigger inside the marker window is not stretched but is counted.
    idle(20);
    base = int'(ppsCount);
    step(1'b1, PPS);
    chk("ppsMarkCycle1", pulsePerSecondMarker, 1);
    idle(1);
    chk("ppsMarkCycle2", pulsePerSecondMarker, 1);
    step(1'b1, PPS);
    chk("ppsMarkCycle3", pulsePerSecondMarker, 1);
    idle(1);
    chk("ppsMarkCycle4", pulsePerSecondMarker, 1);
    idle(1);
    chk("ppsMarkCycle5", pulsePerSecondMarker, 0);
    chk("ppsCountRetrigger", ppsCount, (base + 2) % 65536);

    // Interval counter saturation.
    idle(5000);
    step(1'b1, HB);
    chk("satInterval", heartbeatInterval, MAXV);

    // Lock tracking disabled, intervals still measured.
    expectedInterval = '0;
    for (int i = 0; i < 5; i++) hbAfter(50);
    chk("disabledInterval", heartbeatInterval, 50);
    chk("disabledUnlocked", heartbeatLocked, 0);

    // Randomized heartbeat jitter, timeouts, retriggers, PPS and noise codes.
    e = 20;
    expectedInterval = 12'(e);
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 12) gap = e;
      else if (r < 15) gap = ($urandom_range(0, 1) == 0) ? e - 1 : e + 1;
      else if (r < 17) gap = e + $urandom_range(2, 10);
      else gap = $urandom_range(1, 3);
      for (int j = 0; j < gap - 1; j++) randCycle();
      step(1'b1, HB);
      if ($urandom_range(0, 49) == 0) begin
        e = $urandom_range(0, 30);
        expectedInterval = 12'(e);
        if (e < 4) e = 4;
      end
      if ($urandom_range(0, 149) == 0) doReset();
    end

    // Reset in the middle of a marker pulse; first post-reset heartbeat has no strobe.
    expectedInterval = 12'd1000;
    idle(10);
    step(1'b1, HB);
    idle(1);
    doReset();
    step(1'b1, HB);
    chk("postResetNoStrobe", heartbeatIntervalStrobe, 0);
    chk("postResetHbCount", heartbeatCount, 1);
    chk("postResetMarker", heartbeatMarker, 1);
    idle(10);

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_marker_decode.md
# event_marker_decode

Decodes the EVR event-code stream in the EVR clock domain and produces the heartbeat and pulse-per-second marker pulses consumed by the clock generator. It also measures the heartbeat period, tracks heartbeat lock against a configured interval, and keeps wrap-around event counters for status readback. It sits between the EVR receive datapath and the clock generator/marker watchdogs.

## Interface
Parameters:
- `HEARTBEAT_CODE`, 8'h7A: event code for the heartbeat marker.
- `PPS_CODE`, 8'h7D: event code for the pulse-per-second marker.
- `MARKER_WIDTH`, 4: marker high time in `clk` cycles; legal range 1–15.
- `INTERVAL_WIDTH`, 28: width of the interval counter and the expected/measured interval.
- `LOCK_COUNT`, 3: consecutive matching intervals required to declare lock; legal range 1–7.
- `DEBUG`, "false": drives mark_debug on internal state.

Ports:
- `clk` in 1: EVR recovered clock. This is the only clock.
- `resetN` in 1: asynchronous, active-low reset.
- `evCode` in 8: received event code.
- `evCodeValid` in 1: `evCode` is valid this cycle.
- `expectedInterval` in `INTERVAL_WIDTH`: nominal heartbeat period in `clk` cycles. Quasi-static. A value of 0 disables lock tracking.
- `heartbeatMarker` out 1: stretched heartbeat marker.
- `pulsePerSecondMarker` out 1: stretched PPS marker.
- `heartbeatInterval` out `INTERVAL_WIDTH`: last measured heartbeat period.
- `heartbeatIntervalStrobe` out 1: one-cycle pulse when `heartbeatInterval` updates.
- `heartbeatLocked` out 1: lock FSM is in LOCKED.
- `heartbeatCount` out 16: count of accepted heartbeat events.
- `ppsCount` out 16: count of accepted PPS events.

## Operation
- **Decode:**
  - A heartbeat event is a cycle with `evCodeValid` high and `evCode==HEARTBEAT_CODE`.
  - A PPS event is the same with `evCode==PPS_CODE`.
  - Only one code arrives per cycle, so a heartbeat and a PPS event can never coincide.
- **Marker stretch:** each marker type has its own down-counter.
  - An event while the counter is 0 loads `MARKER_WIDTH` and asserts the marker.
  - An event while the marker is still high is ignored for stretching; the marker is not extended.
  - The event is still counted and still handled by the interval logic.
- **Event counters:** 16-bit, increment on every decoded event, wrap from 0xFFFF to 0.
- **Interval counter:**
  - Increments every cycle and saturates at all-ones.
  - On a heartbeat event it is reloaded with 1.
  - The pre-reload value is latched into `heartbeatInterval` and `heartbeatIntervalStrobe` pulses.
  - The first heartbeat after reset produces no strobe, because there is no reference yet.
- **Lock FSM:** states UNLOCKED, ARMED, LOCKED, plus a 3-bit match count.
  - UNLOCKED → ARMED on a heartbeat (match count 0).
  - ARMED, heartbeat with measured==`expectedInterval`: match count +1. When it reaches `LOCK_COUNT`, go to LOCKED.
  - ARMED, heartbeat with a mismatched interval: stay ARMED, match count 0. This heartbeat becomes the new reference.
  - LOCKED, heartbeat with a mismatched interval: go to ARMED, match count 0.
  - Timeout: in ARMED or LOCKED, if the interval counter exceeds `expectedInterval` with no heartbeat, go to UNLOCKED.
  - A heartbeat arriving in the cycle where timeout would fire wins: it is evaluated as a normal heartbeat.
  - `expectedInterval==0` forces UNLOCKED permanently; intervals are still measured.
  - A change of `expectedInterval` takes effect at the next heartbeat comparison. There is no resynchronisation.

## Timing
- **Reset values:** all outputs 0, FSM UNLOCKED, marker counters 0, interval counter 0, "first heartbeat seen" flag clear.
- **Marker latency:** event sampled at edge N; marker high from N+1 through N+`MARKER_WIDTH`; low at N+`MARKER_WIDTH`+1.
- **Interval latency:** `heartbeatInterval` and `heartbeatIntervalStrobe` update at edge N+1, the same edge the marker rises.
- **Lock latency:** `heartbeatLocked` rises at edge N+1 after the qualifying heartbeat. It falls one cycle after the timeout or mismatch condition.
- **Interval definition:** heartbeats sampled at cycles t0 and t1 report t1−t0.
- **Reset mid-operation:** asserting `resetN` low clears everything immediately (asynchronous). Deassertion is synchronous to `clk` and is handled by the instantiating level.
- **Counter update:** counters update at N+1.

## Structure
- **Shared package:**
  - default event-code constants (`HEARTBEAT_CODE`, `PPS_CODE`);
  - lock-FSM state encoding (2-bit, UNLOCKED=0, ARMED=1, LOCKED=2);
  - `INTERVAL_WIDTH` default.
- **Sub-module `marker_stretch`:** one natural sub-module containing the per-marker down-counter and its retrigger-ignore rule. It is instantiated twice.
- **Top level:** decode, event counters, interval counter and lock FSM.

## Test plan
- **Lock acquisition:** `expectedInterval`=1000, heartbeats every 1000 cycles → strobes report 1000; `heartbeatLocked` rises one cycle after the 4th heartbeat (LOCK_COUNT=3).
- **Timeout:** while locked, withhold the heartbeat → `heartbeatLocked` falls when the counter passes 1000 (cycle 1001 after the last heartbeat). A late heartbeat at 1500 reports 1500 and re-arms.
- **Mismatch:** locked, one heartbeat at 999 → state ARMED, interval 999 reported. Three more at 1000 → relock.
- **Stretch retrigger:** `MARKER_WIDTH`=4, PPS events at cycles 0 and 2 → marker high for cycles 1–4 only; `ppsCount` advances by 2.
- **Saturation/wrap:** no heartbeat for 2^28+5 cycles → the next report is 0xFFFFFFF. 65537 PPS events → `ppsCount`=1.
- **Reset:** assert `resetN` mid-marker → all outputs 0 immediately; the first post-reset heartbeat gives no strobe.
